pixel_writer: RTL and testbench
===============================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 The block SHALL have parameter RES_X, default 64, meaning frame width in pixels.
REQ-002 The block SHALL have parameter RES_Y, default 48, meaning frame height in pixels.
REQ-003 The block SHALL have parameter ZW, default 16, meaning depth word width in bits.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 The block SHALL have port frag_valid, input, 1, meaning a fragment is offered.
REQ-007 The block SHALL have port frag_ready, output, 1, meaning the block accepts the fragment this cycle.
REQ-008 The block SHALL have ports frag_x and frag_y, each input, 16, giving unsigned pixel coordinates.
REQ-009 The block SHALL have port frag_z, input, ZW, giving unsigned depth, where smaller is nearer.
REQ-010 The block SHALL have port frag_rgb, input, 24, packed as R[23:16], G[15:8], B[7:0].
REQ-011 The block SHALL have port clear_req, input, 1, a single-cycle clear request, and port clear_rgb, input, 24, giving the clear colour.
REQ-012 The block SHALL have port dump_req, input, 1, a single-cycle frame readout request.
REQ-013 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_byte (output, 8) and out_last (output, 1), forming the byte stream to the display stage.
REQ-014 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 The block SHALL have port frame_done, output, 1, a one-cycle pulse at the end of a dump.

Function
REQ-016 The block SHALL hold a colour store (24 b) and a depth store (ZW b) of RES_X*RES_Y entries, each addressed as y*RES_X+x.
REQ-017 The FSM SHALL have states CLEAR, IDLE, TEST and DUMP.
REQ-018 In IDLE, the block SHALL serve requests with priority clear_req > dump_req > fragment.
  - Requests arriving outside IDLE SHALL be ignored, not queued.
REQ-019 In IDLE, frag_ready SHALL be high only when clear_req and dump_req are both low; frag_ready SHALL be low in all other states.
REQ-020 On fragment handshake (cycle N), the block SHALL:
  - read stored depth;
  - enter TEST at N+1;
  - in TEST, write colour and depth at the N+1 edge if frag_z < stored z (strict), otherwise discard;
  - return to IDLE at N+2.
  - Peak throughput is one fragment per 2 cycles.
REQ-021 A fragment with frag_x >= RES_X or frag_y >= RES_Y SHALL be accepted and discarded, with no store write and the same 2-cycle timing.
REQ-022 CLEAR SHALL write colour = latched clear_rgb and depth = all-ones to every address, one per cycle, from 0 ascending, then enter IDLE; it takes exactly RES_X*RES_Y cycles.
REQ-023 DUMP SHALL emit 3*RES_X*RES_Y bytes in row-major order (y=0 first, x ascending), bytes per pixel in order B, G, R.
REQ-024 out_byte and out_last SHALL stay stable while out_valid=1 and out_ready=0; out_valid SHALL NOT drop before handshake.
REQ-025 out_last SHALL be high only with the final byte (R of pixel RES_X*RES_Y-1).
REQ-026 frame_done SHALL pulse the cycle after the final byte handshake, coincident with the return to IDLE.
REQ-027 Between handshakes, DUMP SHALL insert at most 2 idle cycles per byte when out_ready is held high.
REQ-028 Stores SHALL NOT be modified during DUMP.
REQ-029 Coordinate and address arithmetic SHALL be unsigned, without truncation for RES_X, RES_Y up to 4096.

Reset
REQ-030 Reset SHALL set: state CLEAR, latched clear colour 24'h000000, frag_ready=0, out_valid=0, out_last=0, frame_done=0, busy=1, and all counters to 0.
REQ-031 The CLEAR state entered by reset SHALL run a full clear before IDLE.
REQ-032 Reset asserted mid-DUMP or mid-CLEAR SHALL abort the operation at the next edge.
  - out_valid SHALL drop that edge.
  - A fresh clear SHALL then begin.

Verification
REQ-033 Reset release -> busy high for exactly RES_X*RES_Y cycles; a dump then yields all-zero bytes, out_last only on byte 3*RES_X*RES_Y-1, and a single frame_done pulse.
REQ-034 Clear with 24'h112233, then fragment (2,1,z=5,24'hAABBCC) -> dump bytes at pixel 1*RES_X+2 are CC,BB,AA; all other pixels are 33,22,11.
REQ-035 Fragments at (3,3): z=10 with 24'hFF0000, then z=10 with 24'h00FF00, then z=4 with 24'h0000FF -> final pixel bytes FF,00,00 (equal depth discarded).
REQ-036 Fragment (RES_X,0) and fragment (0,RES_Y) -> each handshaken, frag_ready low the following cycle, and no pixel changes.
REQ-037 Dump with out_ready toggling randomly (50%) -> byte sequence identical to out_ready held high, and out_byte stable during every stall.
REQ-038 clear_req, dump_req and frag_valid asserted in the same IDLE cycle -> clear runs, the dump is ignored, and the fragment is not accepted until IDLE.

Source files
------------

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - depth-tested framebuffer writer with frame clear and B,G,R byte-stream readout
module pixel_writer #(
  parameter int RES_X = 64,
  parameter int RES_Y = 48,
  parameter int ZW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frag_valid,
  output logic          frag_ready,
  input  logic [15:0]   frag_x,
  input  logic [15:0]   frag_y,
  input  logic [ZW-1:0] frag_z,
  input  logic [23:0]   frag_rgb,
  input  logic          clear_req,
  input  logic [23:0]   clear_rgb,
  input  logic          dump_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_byte,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done
);

  localparam int NPIX = RES_X * RES_Y;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [16:0]   X_LIM     = 17'(RES_X);
  localparam logic [16:0]   Y_LIM     = 17'(RES_Y);

  typedef enum logic [1:0] {CLEAR, IDLE, TEST, DUMP} state_t;
  state_t state, state_nx;

  logic [23:0]   colour_mem [0:NPIX-1];
  logic [ZW-1:0] depth_mem  [0:NPIX-1];

  logic [AW-1:0] clr_addr;
  logic [23:0]   clr_rgb_q;
  logic [AW-1:0] dump_pix;
  logic [1:0]    byte_sel;
  logic          dump_fetch;
  logic [23:0]   rd_rgb;

  logic [AW-1:0] f_addr;
  logic [ZW-1:0] f_z;
  logic [23:0]   f_rgb;
  logic          f_in;
  logic [ZW-1:0] rd_z;

  logic          frag_in;
  logic [AW-1:0] frag_addr;
  logic          frag_hs;
  logic          final_hs;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_rgb;
  logic [ZW-1:0] wr_z;

  // Out-of-frame fragments still read address 0 so the array is never indexed past its end.
  assign frag_in   = ({1'b0, frag_x} < X_LIM) && ({1'b0, frag_y} < Y_LIM);
  assign frag_addr = frag_in ? (AW'(frag_y) * AW'(RES_X) + AW'(frag_x)) : '0;
  assign frag_hs   = frag_valid && frag_ready;
  assign final_hs  = out_valid && out_ready && out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR: if (clr_addr == LAST_ADDR) state_nx = IDLE;
      IDLE: begin
        if (clear_req)       state_nx = CLEAR;
        else if (dump_req)   state_nx = DUMP;
        else if (frag_valid) state_nx = TEST;
      end
      TEST:    state_nx = IDLE;
      DUMP:    if (final_hs) state_nx = IDLE;
      default: state_nx = CLEAR;
    endcase
  end

  always_comb begin
    frag_ready = (state == IDLE) && !clear_req && !dump_req;
    busy       = (state != IDLE);
    out_valid  = (state == DUMP) && !dump_fetch;
    out_last   = out_valid && (byte_sel == 2'd2) && (dump_pix == LAST_ADDR);
    case (byte_sel)
      2'd0:    out_byte = rd_rgb[7:0];
      2'd1:    out_byte = rd_rgb[15:8];
      default: out_byte = rd_rgb[23:16];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr   <= '0;
      clr_rgb_q  <= 24'h000000;
      dump_pix   <= '0;
      byte_sel   <= 2'd0;
      dump_fetch <= 1'b0;
      frame_done <= 1'b0;
      f_addr     <= '0;
      f_z        <= '0;
      f_rgb      <= 24'h000000;
      f_in       <= 1'b0;
    end else begin
      frame_done <= final_hs;
      case (state)
        IDLE: begin
          if (clear_req) begin
            clr_rgb_q <= clear_rgb;
            clr_addr  <= '0;
          end else if (dump_req) begin
            dump_pix   <= '0;
            byte_sel   <= 2'd0;
            dump_fetch <= 1'b1;
          end else if (frag_valid) begin
            f_addr <= frag_addr;
            f_z    <= frag_z;
            f_rgb  <= frag_rgb;
            f_in   <= frag_in;
          end
        end
        CLEAR: clr_addr <= clr_addr + AW'(1);
        DUMP: begin
          // One fetch cycle per pixel, then its three bytes straight from the read register.
          if (dump_fetch) begin
            dump_fetch <= 1'b0;
          end else if (out_ready) begin
            if (byte_sel == 2'd2) begin
              byte_sel   <= 2'd0;
              dump_pix   <= dump_pix + AW'(1);
              dump_fetch <= 1'b1;
            end else begin
              byte_sel <= byte_sel + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = f_addr;
    wr_rgb  = f_rgb;
    wr_z    = f_z;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        wr_rgb  = clr_rgb_q;
        wr_z    = '1;
      end else if (state == TEST && f_in && (f_z < rd_z)) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      colour_mem[wr_addr] <= wr_rgb;
      depth_mem[wr_addr]  <= wr_z;
    end
    if (frag_hs) begin
      rd_z <= depth_mem[frag_addr];
    end
    if (state == DUMP && dump_fetch) begin
      rd_rgb <= colour_mem[dump_pix];
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - directed self-checking bench for pixel_writer on an 8x6 frame
module tb_pixel_writer;
  localparam int RX = 8;
  localparam int RY = 6;
  localparam int NP = RX * RY;
  localparam int NB = 3 * NP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frag_valid = 1'b0;
  logic        frag_ready;
  logic [15:0] frag_x = '0;
  logic [15:0] frag_y = '0;
  logic [15:0] frag_z = '0;
  logic [23:0] frag_rgb = '0;
  logic        clear_req = 1'b0;
  logic [23:0] clear_rgb = '0;
  logic        dump_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        busy;
  logic        frame_done;

  pixel_writer #(.RES_X(RX), .RES_Y(RY), .ZW(16)) dut (
    .clk(clk), .rst(rst),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y), .frag_z(frag_z), .frag_rgb(frag_rgb),
    .clear_req(clear_req), .clear_rgb(clear_rgb), .dump_req(dump_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] exp_px [0:NP-1];
  logic [7:0]  got [0:NB-1];
  int n_bytes, n_last, last_idx, stall_err, fd_early;
  bit fd_after, idle_after, fd_later, dump_to;

  function automatic int frame_errs();
    int e = 0;
    for (int p = 0; p < NP; p++) begin
      logic [23:0] c;
      c = exp_px[p];
      if (got[3*p]   !== c[7:0])   e++;
      if (got[3*p+1] !== c[15:8])  e++;
      if (got[3*p+2] !== c[23:16]) e++;
    end
    return e;
  endfunction

  task automatic set_all(input logic [23:0] c);
    for (int p = 0; p < NP; p++) exp_px[p] = c;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int t = 0; t < 500; t++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_frag(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                         input logic [23:0] rgb, output bit ok, output logic rdy_after);
    ok = 1'b0;
    @(negedge clk);
    frag_valid = 1'b1; frag_x = x; frag_y = y; frag_z = z; frag_rgb = rgb;
    for (int t = 0; t < 300; t++) begin
      #1;
      if (frag_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    rdy_after = frag_ready;
    frag_valid = 1'b0;
  endtask

  task automatic run_dump(input bit rnd);
    bit have_stall = 1'b0;
    logic [7:0] st_byte = '0;
    logic st_last = 1'b0;
    for (int i = 0; i < NB; i++) got[i] = 8'hxx;
    n_bytes = 0; n_last = 0; last_idx = -1; stall_err = 0; fd_early = 0;
    fd_after = 1'b0; idle_after = 1'b0; fd_later = 1'b1; dump_to = 1'b1;
    @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (frame_done) fd_early++;
      if (have_stall && (!out_valid || out_byte !== st_byte || out_last !== st_last)) stall_err++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      have_stall = out_valid && !out_ready;
      st_byte = out_byte;
      st_last = out_last;
      if (out_valid && out_ready) begin
        if (n_bytes < NB) got[n_bytes] = out_byte;
        if (out_last) begin n_last++; last_idx = n_bytes; end
        n_bytes++;
        if (out_last) begin
          @(negedge clk);
          out_ready = 1'b0;
          fd_after = frame_done;
          idle_after = !busy;
          @(negedge clk);
          fd_later = frame_done;
          dump_to = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %b want 1", busy); end
    n_cmp++; if (frag_ready !== 1'b0) begin n_bad++; $display("FAIL rst_frag_ready: got %b want 0", frag_ready); end
    n_cmp++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_bad++; $display("FAIL rst_out: got valid %b last %b want 0 0", out_valid, out_last); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    rst = 1'b0;
    count_busy(n);
    n_cmp++; if (n !== NP) begin n_bad++; $display("FAIL rst_clear_cycles: got %0d want %0d", n, NP); end
    set_all(24'h000000);
    run_dump(1'b0);
    n_cmp++; if (dump_to) begin n_bad++; $display("FAIL rst_dump_timeout: got timeout want completion"); end
    n_cmp++; if (n_bytes !== NB) begin n_bad++; $display("FAIL rst_dump_len: got %0d want %0d", n_bytes, NB); end
    n_cmp++; if (frame_errs() !== 0) begin n_bad++; $display("FAIL rst_dump_data: got %0d bad bytes want 0", frame_errs()); end
    n_cmp++; if (n_last !== 1 || last_idx !== NB - 1) begin n_bad++; $display("FAIL rst_out_last: got count %0d at %0d want 1 at %0d", n_last, last_idx, NB - 1); end
    n_cmp++; if (fd_early !== 0 || fd_after !== 1'b1 || fd_later !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done_pulse: got early %0d after %b later %b want 0 1 0", fd_early, fd_after, fd_later); end
    n_cmp++; if (idle_after !== 1'b1) begin n_bad++; $display("FAIL rst_idle_after_dump: got %b want 1", idle_after); end
  endtask

  task automatic test_clear_frag();
    int n;
    bit ok;
    logic ra;
    @(negedge clk);
    clear_req = 1'b1; clear_rgb = 24'h112233;
    @(negedge clk);
    clear_req = 1'b0;
    count_busy(n);
    n_cmp++; if (n !== NP) begin n_bad++; $display("FAIL clear_cycles: got %0d want %0d", n, NP); end
    do_frag(16'd2, 16'd1, 16'd5, 24'hAABBCC, ok, ra);
    n_cmp++; if (!ok || ra !== 1'b0) begin n_bad++; $display("FAIL frag_handshake: got ok %b ready_after %b want 1 0", ok, ra); end
    set_all(24'h112233);
    exp_px[1*RX+2] = 24'hAABBCC;
    run_dump(1'b0);
    n_cmp++; if (frame_errs() !== 0 || n_bytes !== NB) begin n_bad++; $display("FAIL clear_frag_frame: got %0d bad bytes len %0d want 0 len %0d", frame_errs(), n_bytes, NB); end
  endtask

  task automatic test_depth();
    bit ok1, ok2, ok3;
    logic r1, r2, r3;
    do_frag(16'd3, 16'd3, 16'd10, 24'hFF0000, ok1, r1);
    do_frag(16'd3, 16'd3, 16'd10, 24'h00FF00, ok2, r2);
    do_frag(16'd3, 16'd3, 16'd4,  24'h0000FF, ok3, r3);
    n_cmp++; if (!(ok1 && ok2 && ok3)) begin n_bad++; $display("FAIL depth_handshakes: got %b%b%b want 111", ok1, ok2, ok3); end
    exp_px[3*RX+3] = 24'h0000FF;
    run_dump(1'b0);
    n_cmp++; if (got[3*(3*RX+3)] !== 8'hFF || got[3*(3*RX+3)+1] !== 8'h00 || got[3*(3*RX+3)+2] !== 8'h00) begin
      n_bad++; $display("FAIL depth_pixel: got %h %h %h want ff 00 00", got[3*(3*RX+3)], got[3*(3*RX+3)+1], got[3*(3*RX+3)+2]);
    end
    n_cmp++; if (frame_errs() !== 0) begin n_bad++; $display("FAIL depth_frame: got %0d bad bytes want 0", frame_errs()); end
  endtask

  task automatic test_out_of_range();
    bit ok1, ok2;
    logic r1, r2;
    do_frag(16'(RX), 16'd0, 16'd0, 24'hFFFFFF, ok1, r1);
    do_frag(16'd0, 16'(RY), 16'd0, 24'hFFFFFF, ok2, r2);
    n_cmp++; if (!ok1 || r1 !== 1'b0) begin n_bad++; $display("FAIL oor_x_handshake: got ok %b ready_after %b want 1 0", ok1, r1); end
    n_cmp++; if (!ok2 || r2 !== 1'b0) begin n_bad++; $display("FAIL oor_y_handshake: got ok %b ready_after %b want 1 0", ok2, r2); end
    run_dump(1'b0);
    n_cmp++; if (frame_errs() !== 0) begin n_bad++; $display("FAIL oor_frame: got %0d bad bytes want 0", frame_errs()); end
  endtask

  task automatic test_stall_dump();
    run_dump(1'b1);
    n_cmp++; if (dump_to || n_bytes !== NB) begin n_bad++; $display("FAIL stall_len: got %0d timeout %b want %0d", n_bytes, dump_to, NB); end
    n_cmp++; if (frame_errs() !== 0) begin n_bad++; $display("FAIL stall_frame: got %0d bad bytes want 0", frame_errs()); end
    n_cmp++; if (stall_err !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stall_err); end
    n_cmp++; if (n_last !== 1 || last_idx !== NB - 1 || fd_after !== 1'b1) begin n_bad++; $display("FAIL stall_last: got count %0d at %0d done %b want 1 at %0d done 1", n_last, last_idx, fd_after, NB - 1); end
  endtask

  task automatic test_priority();
    int n = 0;
    int early = 0;
    bit ok = 1'b0;
    @(negedge clk);
    clear_req = 1'b1; clear_rgb = 24'h445566; dump_req = 1'b1;
    frag_valid = 1'b1; frag_x = 16'd0; frag_y = 16'd0; frag_z = 16'd0; frag_rgb = 24'hABCDEF;
    #1;
    n_cmp++; if (frag_ready !== 1'b0) begin n_bad++; $display("FAIL prio_ready: got %b want 0", frag_ready); end
    @(negedge clk);
    clear_req = 1'b0; dump_req = 1'b0;
    for (int t = 0; t < 500; t++) begin
      #1;
      if (out_valid) early++;
      if (frag_ready) begin
        if (busy) early++;
        ok = 1'b1;
        break;
      end
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    frag_valid = 1'b0;
    n_cmp++; if (!ok || n !== NP) begin n_bad++; $display("FAIL prio_clear_first: got ok %b wait %0d want 1 wait %0d", ok, n, NP); end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL prio_no_dump: got %0d bad cycles want 0", early); end
    set_all(24'h445566);
    exp_px[0] = 24'hABCDEF;
    run_dump(1'b0);
    n_cmp++; if (frame_errs() !== 0) begin n_bad++; $display("FAIL prio_frame: got %0d bad bytes want 0", frame_errs()); end
  endtask

  task automatic test_reset_abort();
    int n;
    @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL abort_dump: got valid %b busy %b want 0 1", out_valid, busy); end
    rst = 1'b0;
    count_busy(n);
    n_cmp++; if (n !== NP) begin n_bad++; $display("FAIL abort_dump_clear: got %0d want %0d", n, NP); end
    @(negedge clk);
    clear_req = 1'b1; clear_rgb = 24'hFFFFFF;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    n_cmp++; if (n !== NP) begin n_bad++; $display("FAIL abort_clear_cycles: got %0d want %0d", n, NP); end
    set_all(24'h000000);
    run_dump(1'b0);
    n_cmp++; if (frame_errs() !== 0 || n_bytes !== NB) begin n_bad++; $display("FAIL abort_frame: got %0d bad bytes len %0d want 0 len %0d", frame_errs(), n_bytes, NB); end
  endtask

  initial begin
    test_reset();
    test_clear_frag();
    test_depth();
    test_out_of_range();
    test_stall_dump();
    test_priority();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
